// File: rtl/song_nav_controller_pkg.sv
// Shared constants for the song navigation front-end: play modes and button roles.
package song_nav_controller_pkg;

  localparam logic [2:0] MODE_AUTO   = 3'b011;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_LEARN  = 3'b111;

  localparam int BTN_PREV  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;

endpackage

// File: rtl/song_nav_controller_btn_debounce.sv
// Single-button debouncer: one registered press pulse after GAP consecutive high samples,
// plus an optional hold-repeat pulse every REPEAT cycles (REPEAT=0 builds no repeat logic).
module btn_debounce #(
  parameter int CNT_W  = 25,
  parameter int GAP    = 4,
  parameter int REPEAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rpt_fire;

  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (clr || !btn) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != GAP_C) cnt_d = cnt_q + 1'b1;
      press_d = (cnt_q == GAP_C - 1'b1) || rpt_fire;
    end
  end

  generate
    if (REPEAT > 0) begin : g_rpt
      localparam int RW = $clog2(REPEAT + 1);
      logic [RW-1:0] rpt_q;
      logic          hold;

      // Repeat timing starts only once the debounce counter has saturated.
      assign hold     = btn && !clr && (cnt_q == GAP_C);
      assign rpt_fire = hold && (rpt_q == RW'(REPEAT - 1));

      always_ff @(posedge clk) begin
        if (!rst_n || !hold) rpt_q <= '0;
        else if (rpt_fire)   rpt_q <= '0;
        else                 rpt_q <= rpt_q + 1'b1;
      end
    end else begin : g_norpt
      assign rpt_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/song_nav_controller.sv
// Button front-end: debounced press pulses drive prev/next song selection and pause toggling.
// Optional macro SONG_NAV_AUTO_REPEAT_EN enables hold-repeat on the prev/next buttons.
`ifndef GAP
`define GAP 2000000
`endif
module song_nav_controller
  import song_nav_controller_pkg::*;
#(
  parameter int N_BTN      = 3,
  parameter int CNT_W      = 25,
  parameter int GAP        = `GAP,
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int REPEAT_GAP = 2 * `GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mode,
  input  logic [N_BTN-1:0]  button,
  output logic [N_BTN-1:0]  press,
  output logic              pause,
  output logic [SONG_W-1:0] song_num,
  output logic              song_changed
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  generate
    if (N_BTN < 3 || GAP < 1 || REPEAT_GAP < 1 || NUM_SONGS < 2 ||
        (2 ** SONG_W) < NUM_SONGS) begin : g_bad_param
      $error("song_nav_controller: illegal parameter combination");
    end
  endgenerate

  logic              auto_en, sel_en;
  logic [N_BTN-1:0]  clr, press_w;
  logic [SONG_W-1:0] song_q, song_d;
  logic              pause_q, pause_d;
  logic              changed_q, changed_d;

  assign auto_en = (mode == MODE_AUTO);
  assign sel_en  = (mode == MODE_AUTO) || (mode == MODE_LEARN);

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
`ifdef SONG_NAV_AUTO_REPEAT_EN
      localparam int RPT = (i == BTN_PREV || i == BTN_NEXT) ? REPEAT_GAP : 0;
`else
      localparam int RPT = 0;
`endif
      // Gated buttons lose their count so a mode change restarts debouncing.
      if (i == BTN_PREV || i == BTN_NEXT) begin : g_sel
        assign clr[i] = !sel_en;
      end else if (i == BTN_PAUSE) begin : g_pause
        assign clr[i] = !auto_en;
      end else begin : g_free
        assign clr[i] = 1'b0;
      end

      btn_debounce #(
        .CNT_W  (CNT_W),
        .GAP    (GAP),
        .REPEAT (RPT)
      ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr[i]),
        .btn   (button[i]),
        .press (press_w[i])
      );
    end
  endgenerate

  always_comb begin
    song_d    = song_q;
    changed_d = 1'b0;
    pause_d   = pause_q;
    if (!sel_en) begin
      song_d = '0;
    end else if (press_w[BTN_PREV] ^ press_w[BTN_NEXT]) begin
      changed_d = 1'b1;
      if (press_w[BTN_NEXT]) song_d = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
      else                   song_d = (song_q == '0) ? LAST_SONG : song_q - 1'b1;
    end
    // A song change wins over a simultaneous pause toggle.
    if (!auto_en || changed_d)  pause_d = 1'b0;
    else if (press_w[BTN_PAUSE]) pause_d = !pause_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      song_q    <= '0;
      pause_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      song_q    <= song_d;
      pause_q   <= pause_d;
      changed_q <= changed_d;
    end
  end

  assign press        = press_w;
  assign song_num     = song_q;
  assign pause        = pause_q;
  assign song_changed = changed_q;

endmodule
